cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-cycle-style MIPS datapath (`regfile`, `ALU`, `datamemory`, write-back muxes). It owns the PC, fetches instruction words from instruction memory over a req/ack handshake, decodes the supported subset, and drives the datapath control strobes one phase per cycle. Branch and jump resolution also lives here, using the datapath's `Alu_zero` and `Da` feedback.

---
 rtl/seq_pkg.sv | 48 ++++
 rtl/seq_decoder.sv | 41 ++++
 rtl/cpu_sequencer.sv | 151 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, ALU and
// RegDst codes, FSM states and the decoded-control bundle.
package seq_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_XOR  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;

   localparam logic [1:0] DST_RD   = 2'd0;
   localparam logic [1:0] DST_RT   = 2'd1;
   localparam logic [1:0] DST_R31  = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   // IC_ALU is the zero encoding so a cleared bundle routes through WB.
   typedef enum logic [2:0] {
      IC_ALU, IC_LW, IC_SW, IC_J, IC_JAL, IC_JR, IC_BNE
   } iclass_t;

   typedef struct packed {
      iclass_t    iclass;
      logic [1:0] reg_dst;
      logic [2:0] alu_cntrl;
      logic       alu_src;
      logic       mem_to_reg;
      logic       wb_link;
      logic       ovf_chk;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/seq_decoder.sv
// Purely combinational opcode/funct decode into datapath control fields.
// Unsupported encodings return an all-zero bundle with only the illegal flag set.
module seq_decoder
   import seq_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      // NOTE: every combinational output gets a default before the case so no path can infer a latch.
      dec = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin dec.alu_cntrl = ALU_ADD; dec.ovf_chk = 1'b1; end
               FN_SUB: begin dec.alu_cntrl = ALU_SUB; dec.ovf_chk = 1'b1; end
               FN_SLT: dec.alu_cntrl = ALU_SLT;
               FN_JR:  dec.iclass    = IC_JR;
               default: dec.illegal  = 1'b1;
            endcase
         end
         OP_J:   dec.iclass = IC_J;
         OP_JAL: begin dec.iclass = IC_JAL; dec.reg_dst = DST_R31; dec.wb_link = 1'b1; end
         OP_BNE: begin dec.iclass = IC_BNE; dec.alu_cntrl = ALU_SUB; end
         OP_ADDI: begin
            dec.reg_dst = DST_RT; dec.alu_src = 1'b1;
            dec.alu_cntrl = ALU_ADD; dec.ovf_chk = 1'b1;
         end
         OP_XORI: begin dec.reg_dst = DST_RT; dec.alu_src = 1'b1; dec.alu_cntrl = ALU_XOR; end
         OP_LW: begin
            dec.iclass = IC_LW; dec.reg_dst = DST_RT; dec.alu_src = 1'b1;
            dec.alu_cntrl = ALU_ADD; dec.mem_to_reg = 1'b1;
         end
         OP_SW: begin dec.iclass = IC_SW; dec.alu_src = 1'b1; dec.alu_cntrl = ALU_ADD; end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle MIPS control sequencer: PC, fetch handshake, FSM and branch/jump resolution.
// Optional overflow trap on ADD/ADDI/SUB is enabled with `define SEQ_OVERFLOW_TRAP_EN.
module cpu_sequencer
   import seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        Alu_zero,
   input  logic        Alu_overflow,
   input  logic [31:0] Da,
   output logic        RegWr,
   output logic        MemWr,
   output logic        MemToReg,
   output logic        ALUSrc,
   output logic [1:0]  RegDst,
   output logic [2:0]  ALUcntrl,
   output logic [4:0]  Rs,
   output logic [4:0]  Rt,
   output logic [4:0]  Rd,
   output logic [4:0]  R31,
   output logic [15:0] imm16,
   output logic [31:0] Jal_out,
   input  logic [31:0] wb_data,
   output logic        wb_link,
   output logic [31:0] pc,
   output logic        retire,
   output logic        halted,
   output logic        trap
);

   state_t      state, state_next;
   dec_t        dec;
   logic [31:0] ir, pc_next, pc_plus4, br_target, j_target;
   logic        req_raw, reg_wr_raw, mem_wr_raw, retire_raw, ovf_fault;

   seq_decoder u_decoder (
      .opcode (ir[31:26]),
      .funct  (ir[5:0]),
      .dec    (dec)
   );

   // Fields decode straight from IR, so they hold from DECODE until the next fetch lands.
   assign Rs        = ir[25:21];
   assign Rt        = ir[20:16];
   assign Rd        = ir[15:11];
   assign R31       = 5'd31;
   assign imm16     = ir[15:0];
   assign RegDst    = dec.reg_dst;
   assign ALUcntrl  = dec.alu_cntrl;
   assign ALUSrc    = dec.alu_src;
   assign MemToReg  = dec.mem_to_reg;
   assign wb_link   = dec.wb_link;
   assign imem_addr = pc;

   assign pc_plus4  = pc + 32'd4;
   assign br_target = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
   assign j_target  = {pc_plus4[31:28], ir[25:0], 2'b00};
   assign Jal_out   = wb_link ? pc_plus4 : wb_data;

`ifdef SEQ_OVERFLOW_TRAP_EN
   assign ovf_fault = dec.ovf_chk & Alu_overflow;
`else
   logic unused_ovf;
   assign ovf_fault  = 1'b0;
   assign unused_ovf = Alu_overflow ^ dec.ovf_chk;
`endif

   always_comb begin
      state_next = state;
      pc_next    = pc;
      req_raw    = 1'b0;
      reg_wr_raw = 1'b0;
      mem_wr_raw = 1'b0;
      retire_raw = 1'b0;
      case (state)
         S_FETCH: begin
            req_raw = 1'b1;
            if (imem_ack) state_next = S_DECODE;
         end
         S_DECODE: state_next = dec.illegal ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (dec.iclass)
               IC_J:   begin pc_next = j_target; retire_raw = 1'b1; state_next = S_FETCH; end
               IC_JR:  begin pc_next = Da;       retire_raw = 1'b1; state_next = S_FETCH; end
               IC_BNE: begin
                  pc_next    = Alu_zero ? pc_plus4 : br_target;
                  retire_raw = 1'b1;
                  state_next = S_FETCH;
               end
               IC_LW, IC_SW: state_next = S_MEM;
               default:      state_next = ovf_fault ? S_HALT : S_WB;
            endcase
         end
         S_MEM: begin
            if (dec.iclass == IC_SW) begin
               mem_wr_raw = 1'b1;
               retire_raw = 1'b1;
               pc_next    = pc_plus4;
               state_next = S_FETCH;
            end else begin
               state_next = S_WB;
            end
         end
         S_WB: begin
            reg_wr_raw = 1'b1;
            retire_raw = 1'b1;
            pc_next    = (dec.iclass == IC_JAL) ? j_target : pc_plus4;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   // Strobes are masked during reset so an aborted instruction never writes.
   assign imem_req = req_raw    & ~reset;
   assign RegWr    = reg_wr_raw & ~reset;
   assign MemWr    = mem_wr_raw & ~reset;
   assign retire   = retire_raw & ~reset;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_FETCH;
         pc     <= RESET_PC;
         ir     <= '0;
         halted <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (state == S_FETCH && imem_ack) ir <= imem_data;
         if (state == S_DECODE && dec.illegal) halted <= 1'b1;
      end
   end

`ifdef SEQ_OVERFLOW_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset)                          trap <= 1'b0;
      else if (state == S_EXEC && ovf_fault) trap <= 1'b1;
   end
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks a short program through every instruction
// class, branch/jump targets, PC wrap, illegal halt, reset abort and overflow handling.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_data;
   logic        Alu_zero, Alu_overflow;
   logic [31:0] Da, wb_data, Jal_out, pc;
   logic        RegWr, MemWr, MemToReg, ALUSrc, wb_link, retire, halted, trap;
   logic [1:0]  RegDst;
   logic [2:0]  ALUcntrl;
   logic [4:0]  Rs, Rt, Rd, R31;
   logic [15:0] imm16;

   int n_total = 0;
   int n_pass  = 0;

   cpu_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .Alu_zero(Alu_zero), .Alu_overflow(Alu_overflow), .Da(Da),
      .RegWr(RegWr), .MemWr(MemWr), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
      .RegDst(RegDst), .ALUcntrl(ALUcntrl),
      .Rs(Rs), .Rt(Rt), .Rd(Rd), .R31(R31), .imm16(imm16),
      .Jal_out(Jal_out), .wb_data(wb_data), .wb_link(wb_link),
      .pc(pc), .retire(retire), .halted(halted), .trap(trap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Called at a FETCH negedge; returns at the negedge of the expected retire cycle.
   task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] exp_pc,
                        input int stall, input int lat);
      for (int i = 0; i < stall; i++) begin
         check({tag, " stall_req"}, imem_req, 1);
         step();
      end
      check({tag, " req"}, imem_req, 1);
      check({tag, " addr"}, imem_addr, exp_pc);
      imem_ack  = 1'b1;
      imem_data = instr;
      step();
      imem_ack  = 1'b0;
      imem_data = 32'hDEAD_BEEF;
      for (int i = 1; i < lat; i++) begin
         check({tag, " early_strobe"}, {RegWr, MemWr, retire}, 0);
         step();
      end
      check({tag, " retire"}, retire, 1);
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_data = '0;
      Alu_zero = 1'b0; Alu_overflow = 1'b0; Da = '0; wb_data = 32'h5555_AAAA;

      // Reset state
      step();
      check("rst_req", imem_req, 0);
      check("rst_pc", pc, 32'h0);
      check("rst_strobes", {RegWr, MemWr, retire, halted, trap, wb_link}, 0);
      check("rst_fields", {RegDst, ALUcntrl, ALUSrc, MemToReg, Rs, Rt, Rd, imm16}, 0);
      check("rst_r31", R31, 31);
      step();
      check("rst2_req", imem_req, 0);
      reset = 1'b0;
      step();

      // ADDI $t0,$zero,5 acked on third request cycle
      issue("addi", 32'h2008_0005, 32'h0, 2, 3);
      check("addi_regwr", {RegWr, MemWr}, 2'b10);
      check("addi_ctl", {RegDst, Rt, ALUSrc, ALUcntrl}, {2'd1, 5'd8, 1'b1, 3'd0});
      step();
      check("addi_next_pc", imem_addr, 32'h4);
      check("addi_regwr_off", RegWr, 0);

      // XORI $t1,$t0,3
      issue("xori", 32'h3909_0003, 32'h4, 0, 3);
      check("xori_ctl", {RegWr, RegDst, ALUSrc, ALUcntrl, Rs, Rt, imm16},
            {1'b1, 2'd1, 1'b1, 3'd2, 5'd8, 5'd9, 16'h0003});
      step();

      // SW $t1,4($t0)
      issue("sw", 32'hAD09_0004, 32'h8, 0, 3);
      check("sw_memwr", {MemWr, RegWr, ALUSrc}, 3'b101);
      step();
      check("sw_memwr_off", MemWr, 0);

      // LW $t2,8($t0)
      issue("lw", 32'h8D0A_0008, 32'hC, 0, 4);
      check("lw_ctl", {RegWr, MemWr, MemToReg, RegDst, Rt}, {1'b1, 1'b0, 1'b1, 2'd1, 5'd10});
      step();

      // BNE imm=-1: taken loops to itself, not-taken falls through
      Alu_zero = 1'b0;
      issue("bne_taken", 32'h1509_FFFF, 32'h10, 0, 2);
      check("bne_no_wr", {RegWr, MemWr, ALUcntrl}, {2'b00, 3'd1});
      step();
      check("bne_taken_pc", pc, 32'h10);
      Alu_zero = 1'b1;
      issue("bne_fall", 32'h1509_FFFF, 32'h10, 0, 2);
      check("bne_fall_no_wr", {RegWr, MemWr}, 0);
      step();
      check("bne_fall_pc", pc, 32'h14);
      Alu_zero = 1'b0;

      // J 0x20
      issue("j", 32'h0800_0008, 32'h14, 0, 2);
      step();
      check("j_pc", pc, 32'h20);

      // JAL 0x100 from 0x20
      issue("jal", 32'h0C00_0040, 32'h20, 0, 3);
      check("jal_wb", {RegWr, RegDst, wb_link}, {1'b1, 2'd2, 1'b1});
      check("jal_out", Jal_out, 32'h24);
      step();
      check("jal_pc", pc, 32'h100);

      // JR $ra with Da=0x24
      Da = 32'h24;
      issue("jr", 32'h03E0_0008, 32'h100, 0, 2);
      check("jr_no_wr", {RegWr, MemWr, wb_link}, 0);
      check("jr_jal_out_passthru", Jal_out, 32'h5555_AAAA);
      step();
      check("jr_pc", pc, 32'h24);

      // ADD $t3,$t0,$t1 and SLT $t4,$t0,$t1
      issue("add", 32'h0109_5820, 32'h24, 0, 3);
      check("add_ctl", {RegWr, RegDst, Rd, ALUSrc, ALUcntrl}, {1'b1, 2'd0, 5'd11, 1'b0, 3'd0});
      step();
      issue("slt", 32'h0109_602A, 32'h28, 0, 3);
      check("slt_ctl", {RegWr, Rd, ALUcntrl}, {1'b1, 5'd12, 3'd3});
      step();

      // ADD with overflow flagged in EXEC
      Alu_overflow = 1'b1;
`ifdef SEQ_OVERFLOW_TRAP_EN
      check("ovf_addr", imem_addr, 32'h2C);
      imem_ack = 1'b1; imem_data = 32'h0109_5820;
      step();
      imem_ack = 1'b0;
      step();
      check("ovf_exec_retire", retire, 0);
      step();
      check("ovf_trap", {trap, RegWr, retire, imem_req}, 4'b1000);
      check("ovf_pc_held", pc, 32'h2C);
      step();
      check("ovf_still_quiet", {RegWr, MemWr, imem_req, trap}, 4'b0001);
`else
      issue("ovf_ignored", 32'h0109_5820, 32'h2C, 0, 3);
      check("ovf_regwr", {RegWr, trap}, 2'b10);
      step();
      check("ovf_pc", pc, 32'h30);
`endif
      Alu_overflow = 1'b0;

      // Ack coincident with reset is ignored
      reset = 1'b1; imem_ack = 1'b1; imem_data = 32'hFFFF_FFFF;
      step();
      check("rst_ack_req", imem_req, 0);
      check("rst_ack_pc", pc, 32'h0);
      step();
      reset = 1'b0; imem_ack = 1'b0;
      step();
      check("rst_ack_still_fetch", {imem_req, Rs, halted, trap}, {1'b1, 5'd0, 1'b0, 1'b0});

      // Reset during EXEC of ADD aborts with no write
      imem_ack = 1'b1; imem_data = 32'h0109_5820;
      step();
      imem_ack = 1'b0;
      step();
      reset = 1'b1;
      step();
      check("abort_quiet", {RegWr, MemWr, retire, imem_req}, 0);
      check("abort_pc", pc, 32'h0);
      reset = 1'b0;
      step();
      check("abort_refetch", {imem_req, RegWr, MemWr}, 3'b100);
      check("abort_pc2", imem_addr, 32'h0);

      // PC wrap: JR to 0xFFFF_FFFC, then ADDI wraps to 0
      Da = 32'hFFFF_FFFC;
      issue("jr_wrap", 32'h03E0_0008, 32'h0, 0, 2);
      step();
      check("wrap_top_pc", pc, 32'hFFFF_FFFC);
      issue("addi_wrap", 32'h2008_0005, 32'hFFFF_FFFC, 0, 3);
      step();
      check("wrap_pc", pc, 32'h0);

      // Illegal opcode 0x3F halts for good
      imem_ack = 1'b1; imem_data = 32'hFC00_0000;
      step();
      imem_ack = 1'b0;
      check("ill_decode_halted", halted, 0);
      step();
      check("ill_halted", {halted, imem_req}, 2'b10);
      imem_ack = 1'b1;
      step();
      step();
      check("ill_absorbing", {halted, imem_req, RegWr, MemWr, retire}, 5'b10000);
      check("ill_pc", pc, 32'h0);
      imem_ack = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
